// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED driver: OFF/ON/BLINK/PWM per channel on a shared tick
module led_pattern_gen #(
    parameter int NUM_LED    = 4,
    parameter int TICK_DIV   = 50_000,
    parameter int PER_W      = 10,
    parameter int RST_PERIOD = 499,
    localparam int CH_W      = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [PER_W-1:0]   cfg_period,
    input  logic [7:0]         cfg_duty,
    input  logic               resync,
    output logic               tick,
    output logic [NUM_LED-1:0] led
);

    localparam int PS_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } mode_e;

    logic [PS_W-1:0]    ps_q, ps_d;
    logic               tick_q, tick_d;
    logic [7:0]         pwm_q;
    logic [NUM_LED-1:0] led_q, led_d;

    mode_e              mode_q   [NUM_LED];
    mode_e              mode_d   [NUM_LED];
    logic [PER_W-1:0]   period_q [NUM_LED];
    logic [PER_W-1:0]   period_d [NUM_LED];
    logic [7:0]         duty_q   [NUM_LED];
    logic [7:0]         duty_d   [NUM_LED];
    logic [PER_W-1:0]   phase_q  [NUM_LED];
    logic [PER_W-1:0]   phase_d  [NUM_LED];
    logic [NUM_LED-1:0] blink_q, blink_d;

    always_comb begin
        tick_d = (ps_q == PS_W'(TICK_DIV - 1));
        ps_d   = tick_d ? '0 : ps_q + 1'b1;
        if (resync) begin
            ps_d   = '0;
            tick_d = 1'b0;
        end

        led_d   = '0;
        blink_d = blink_q;
        for (int i = 0; i < NUM_LED; i++) begin
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            duty_d[i]   = duty_q[i];
            phase_d[i]  = phase_q[i];

            // A write to this channel overrides both resync and a coincident tick.
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                mode_d[i]   = mode_e'(cfg_mode);
                period_d[i] = cfg_period;
                duty_d[i]   = cfg_duty;
                phase_d[i]  = '0;
                blink_d[i]  = 1'b0;
            end else if (resync) begin
                phase_d[i] = '0;
                blink_d[i] = 1'b0;
            end else if (tick_q && (mode_q[i] == MODE_BLINK)) begin
                if (phase_q[i] >= period_q[i]) begin
                    phase_d[i] = '0;
                    blink_d[i] = ~blink_q[i];
                end else begin
                    phase_d[i] = phase_q[i] + 1'b1;
                end
            end

            case (mode_q[i])
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = blink_q[i];
                MODE_PWM:   led_d[i] = (pwm_q < duty_q[i]);
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q    <= '0;
            tick_q  <= 1'b0;
            pwm_q   <= '0;
            led_q   <= '0;
            blink_q <= '0;
            for (int i = 0; i < NUM_LED; i++) begin
                mode_q[i]   <= MODE_OFF;
                period_q[i] <= PER_W'(RST_PERIOD);
                duty_q[i]   <= '0;
                phase_q[i]  <= '0;
            end
        end else begin
            ps_q    <= ps_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_q + 8'd1;
            led_q   <= led_d;
            blink_q <= blink_d;
            for (int i = 0; i < NUM_LED; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                duty_q[i]   <= duty_d[i];
                phase_q[i]  <= phase_d[i];
            end
        end
    end

    assign tick = tick_q;
    assign led  = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed self-checking bench for led_pattern_gen
module tb_led_pattern_gen;

    localparam int NUM_LED    = 4;
    localparam int TICK_DIV   = 4;
    localparam int PER_W      = 4;
    localparam int RST_PERIOD = 15;
    localparam int CH_W       = 2;

    localparam logic [1:0] M_OFF = 2'b00, M_ON = 2'b01, M_BLINK = 2'b10, M_PWM = 2'b11;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [CH_W-1:0]    cfg_ch = '0;
    logic [1:0]         cfg_mode = '0;
    logic [PER_W-1:0]   cfg_period = '0;
    logic [7:0]         cfg_duty = '0;
    logic               resync = 1'b0;
    logic               tick;
    logic [NUM_LED-1:0] led;

    int vectors = 0;
    int miscompares = 0;
    int e = 0;
    int base = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .NUM_LED    (NUM_LED),
        .TICK_DIV   (TICK_DIV),
        .PER_W      (PER_W),
        .RST_PERIOD (RST_PERIOD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .resync     (resync),
        .tick       (tick),
        .led        (led)
    );

    // Advance one rising edge; inputs are driven and outputs sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
        e++;
    endtask

    task automatic write_ch(input logic [CH_W-1:0] ch, input logic [1:0] mode,
                            input logic [PER_W-1:0] per, input logic [7:0] duty);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_mode   = mode;
        cfg_period = per;
        cfg_duty   = duty;
        cyc();
        cfg_we     = 1'b0;
    endtask

    // Stop so that the next edge has prescaler alignment m relative to base.
    task automatic align(input int m);
        while (((e + 1 - base) % TICK_DIV) != m) cyc();
    endtask

    task automatic test_reset();
        logic exp_t;
        rst_n = 1'b0;
        cyc();
        cyc();
        vectors++;
        if (led !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_led_in_reset got %b want 0000", led);
        end
        vectors++;
        if (tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tick_in_reset got %b want 0", tick);
        end
        rst_n = 1'b1;
        e = 0;
        base = 0;
        for (int j = 1; j <= 200; j++) begin
            cyc();
            exp_t = ((e % TICK_DIV) == 0);
            vectors++;
            if (led !== 4'b0000) begin
                miscompares++;
                $display("FAIL idle_led edge %0d got %b want 0000", e, led);
            end
            vectors++;
            if (tick !== exp_t) begin
                miscompares++;
                $display("FAIL idle_tick edge %0d got %b want %b", e, tick, exp_t);
            end
        end
    endtask

    task automatic test_blink();
        logic [3:0] exp_led;
        align(2);
        write_ch(0, M_BLINK, 4'd2, 8'd0);
        for (int j = 1; j <= 48; j++) begin
            cyc();
            exp_led = {3'b000, ((j / 12) % 2) == 1};
            vectors++;
            if (led !== exp_led) begin
                miscompares++;
                $display("FAIL blink_p2 j=%0d got %b want %b", j, led, exp_led);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2, c3;
        write_ch(1, M_ON, 4'd0, 8'd0);
        vectors++;
        if (led[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL on_latency_early got %b want 0", led[1]);
        end
        write_ch(2, M_PWM, 4'd0, 8'd64);
        vectors++;
        if (led[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL on_latency got %b want 1", led[1]);
        end
        write_ch(3, M_PWM, 4'd0, 8'd0);
        cyc();
        c1 = 0; c2 = 0; c3 = 0;
        for (int j = 0; j < 256; j++) begin
            cyc();
            c1 += int'(led[1]);
            c2 += int'(led[2]);
            c3 += int'(led[3]);
        end
        vectors++;
        if (c1 != 256) begin
            miscompares++;
            $display("FAIL on_count got %0d want 256", c1);
        end
        vectors++;
        if (c2 != 64) begin
            miscompares++;
            $display("FAIL pwm64_count got %0d want 64", c2);
        end
        vectors++;
        if (c3 != 0) begin
            miscompares++;
            $display("FAIL pwm0_count got %0d want 0", c3);
        end
        write_ch(2, M_PWM, 4'd0, 8'd255);
        cyc();
        c2 = 0;
        for (int j = 0; j < 256; j++) begin
            cyc();
            c2 += int'(led[2]);
        end
        vectors++;
        if (c2 != 255) begin
            miscompares++;
            $display("FAIL pwm255_count got %0d want 255", c2);
        end
    endtask

    task automatic test_period_change();
        logic exp_b;
        align(2);
        write_ch(0, M_BLINK, 4'd9, 8'd0);
        repeat (27) cyc();
        write_ch(0, M_BLINK, 4'd3, 8'd0);
        for (int j = 1; j <= 20; j++) begin
            cyc();
            exp_b = (j >= 16);
            vectors++;
            if (led[0] !== exp_b) begin
                miscompares++;
                $display("FAIL period_lower j=%0d got %b want %b", j, led[0], exp_b);
            end
        end
        align(2);
        write_ch(0, M_BLINK, 4'd9, 8'd0);
        repeat (30) cyc();
        write_ch(0, M_BLINK, 4'd3, 8'd0);
        for (int j = 1; j <= 20; j++) begin
            cyc();
            exp_b = (j >= 17);
            vectors++;
            if (led[0] !== exp_b) begin
                miscompares++;
                $display("FAIL write_on_tick j=%0d got %b want %b", j, led[0], exp_b);
            end
        end
    endtask

    task automatic test_resync();
        logic       b;
        logic       exp_t;
        logic [3:0] exp_led;
        write_ch(2, M_OFF, 4'd0, 8'd0);
        write_ch(3, M_OFF, 4'd0, 8'd0);
        write_ch(0, M_BLINK, 4'd1, 8'd0);
        repeat (5) cyc();
        write_ch(1, M_BLINK, 4'd1, 8'd0);
        repeat (14) cyc();
        resync = 1'b1;
        cyc();
        resync = 1'b0;
        base = e;
        for (int j = 1; j <= 32; j++) begin
            cyc();
            b = (j >= 10) ? ((((j - 10) / 8) + 1) % 2 == 1) : 1'b0;
            exp_led = {2'b00, b, b};
            exp_t = ((j % TICK_DIV) == 0);
            vectors++;
            if (led !== exp_led) begin
                miscompares++;
                $display("FAIL resync_led j=%0d got %b want %b", j, led, exp_led);
            end
            vectors++;
            if (tick !== exp_t) begin
                miscompares++;
                $display("FAIL resync_tick j=%0d got %b want %b", j, tick, exp_t);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic exp_t;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (led !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset_led got %b want 0000", led);
        end
        vectors++;
        if (tick !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_tick got %b want 0", tick);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        e = 0;
        base = 0;
        for (int j = 1; j <= 8; j++) begin
            cyc();
            exp_t = ((e % TICK_DIV) == 0);
            vectors++;
            if (led !== 4'b0000) begin
                miscompares++;
                $display("FAIL post_reset_led edge %0d got %b want 0000", e, led);
            end
            vectors++;
            if (tick !== exp_t) begin
                miscompares++;
                $display("FAIL post_reset_tick edge %0d got %b want %b", e, tick, exp_t);
            end
        end
    endtask

    task automatic test_we_low();
        cfg_we   = 1'b0;
        cfg_ch   = 2'd0;
        cfg_mode = M_ON;
        repeat (6) cyc();
        vectors++;
        if (led !== 4'b0000) begin
            miscompares++;
            $display("FAIL we_low_ignored got %b want 0000", led);
        end
        write_ch(0, M_ON, 4'd0, 8'd0);
        cyc();
        vectors++;
        if (led !== 4'b0001) begin
            miscompares++;
            $display("FAIL write_after_reset got %b want 0001", led);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_blink();
        test_back_to_back();
        test_period_change();
        test_resync();
        vectors++;
        if (led !== 4'b0011) begin
            miscompares++;
            $display("FAIL pre_reset_led got %b want 0011", led);
        end
        test_reset_mid();
        test_we_low();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
